instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_instr_decode_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: one-entry output register with valid/ready handshake.
// Optional per-type decode counters under macro DECODE_STATS_EN.
module instr_decode_stage #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned J_OP_LO = 1,
   parameter int unsigned J_OP_HI = 3,
   parameter int unsigned MAX_OP  = 63,
   parameter int unsigned CNT_W   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:0]      out_type,
   output logic [5:0]      out_opcode,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_shamt,
   output logic [5:0]      out_funct,
   output logic [31:0]     out_imm,
   output logic [25:0]     out_target,
   output logic [PC_W-1:0] out_pc
`ifdef DECODE_STATS_EN
   ,
   output logic [CNT_W-1:0] cnt_r,
   output logic [CNT_W-1:0] cnt_i,
   output logic [CNT_W-1:0] cnt_j,
   output logic [CNT_W-1:0] cnt_ill
`endif
);

   localparam logic [1:0] T_R   = 2'b00;
   localparam logic [1:0] T_I   = 2'b01;
   localparam logic [1:0] T_J   = 2'b10;
   localparam logic [1:0] T_ILL = 2'b11;

   logic            valid_q, valid_d;
   logic [1:0]      type_q, type_d;
   logic [31:0]     instr_q, instr_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      dec_type;
   logic [31:0]     op_ext;
   logic            is_r, is_ill, is_j;
   logic            load;

   assign in_ready = rst || flush || !valid_q || out_ready;
   assign load     = in_valid && in_ready && !flush && !rst;

   // Illegal wins over J when the configured ranges overlap.
   assign op_ext = {26'd0, in_instr[31:26]};
   assign is_r   = (op_ext == 32'd0);
   assign is_ill = !is_r && (op_ext > MAX_OP);
   assign is_j   = !is_r && !is_ill
                && (op_ext >= J_OP_LO) && (op_ext <= J_OP_HI);

   always_comb begin
      dec_type = T_I;
      unique case (1'b1)
         is_r:    dec_type = T_R;
         is_ill:  dec_type = T_ILL;
         is_j:    dec_type = T_J;
         default: dec_type = T_I;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      type_d  = type_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         type_d  = dec_type;
         instr_d = in_instr;
         pc_d    = in_pc;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         type_q  <= T_R;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         type_q  <= type_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_type   = type_q;
   assign out_opcode = instr_q[31:26];
   assign out_rs     = instr_q[25:21];
   assign out_rt     = instr_q[20:16];
   assign out_rd     = instr_q[15:11];
   assign out_shamt  = instr_q[10:6];
   assign out_funct  = instr_q[5:0];
   assign out_imm    = {{16{instr_q[15]}}, instr_q[15:0]};
   assign out_target = instr_q[25:0];
   assign out_pc     = pc_q;

`ifdef DECODE_STATS_EN
   logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
   logic [CNT_W-1:0] cnt_i_q, cnt_i_d;
   logic [CNT_W-1:0] cnt_j_q, cnt_j_d;
   logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;

   // Counters saturate at all-ones instead of wrapping.
   always_comb begin
      cnt_r_d   = cnt_r_q;
      cnt_i_d   = cnt_i_q;
      cnt_j_d   = cnt_j_q;
      cnt_ill_d = cnt_ill_q;
      if (load) begin
         unique case (dec_type)
            T_R:
               if (cnt_r_q != '1) cnt_r_d = cnt_r_q + CNT_W'(1);
            T_I:
               if (cnt_i_q != '1) cnt_i_d = cnt_i_q + CNT_W'(1);
            T_J:
               if (cnt_j_q != '1) cnt_j_d = cnt_j_q + CNT_W'(1);
            default:
               if (cnt_ill_q != '1) cnt_ill_d = cnt_ill_q + CNT_W'(1);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r_q   <= '0;
         cnt_i_q   <= '0;
         cnt_j_q   <= '0;
         cnt_ill_q <= '0;
      end else begin
         cnt_r_q   <= cnt_r_d;
         cnt_i_q   <= cnt_i_d;
         cnt_j_q   <= cnt_j_d;
         cnt_ill_q <= cnt_ill_d;
      end
   end

   assign cnt_r   = cnt_r_q;
   assign cnt_i   = cnt_i_q;
   assign cnt_j   = cnt_j_q;
   assign cnt_ill = cnt_ill_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: vector table, hand sequences, random vs model.
// Two instances: defaults, and MAX_OP=40 / CNT_W=2 for illegal and saturation.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        rdy1, val1, rdy2, val2;
   logic [1:0]  typ1, typ2;
   logic [5:0]  op1, fn1, op2, fn2;
   logic [4:0]  rs1, rt1, rd1, sh1, rs2, rt2, rd2, sh2;
   logic [31:0] imm1, pc1, imm2, pc2;
   logic [25:0] tg1, tg2;
`ifdef DECODE_STATS_EN
   logic [15:0] c1r, c1i, c1j, c1x;
   logic [1:0]  c2r, c2i, c2j, c2x;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_decode_stage dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(val1), .out_ready(out_ready), .out_type(typ1),
      .out_opcode(op1), .out_rs(rs1), .out_rt(rt1), .out_rd(rd1),
      .out_shamt(sh1), .out_funct(fn1), .out_imm(imm1),
      .out_target(tg1), .out_pc(pc1)
`ifdef DECODE_STATS_EN
      , .cnt_r(c1r), .cnt_i(c1i), .cnt_j(c1j), .cnt_ill(c1x)
`endif
   );

   instr_decode_stage #(.MAX_OP(40), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(val2), .out_ready(out_ready), .out_type(typ2),
      .out_opcode(op2), .out_rs(rs2), .out_rt(rt2), .out_rd(rd2),
      .out_shamt(sh2), .out_funct(fn2), .out_imm(imm2),
      .out_target(tg2), .out_pc(pc2)
`ifdef DECODE_STATS_EN
      , .cnt_r(c2r), .cnt_i(c2i), .cnt_j(c2j), .cnt_ill(c2x)
`endif
   );

   // Model: at most one held instruction, plus per-type counts.
   logic [31:0] q_instr[$];
   logic [31:0] q_pc[$];
   int cnt1[4];
   int cnt2[4];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_type(logic [31:0] instr, int max_op);
      int op;
      op = int'(instr / 32'd67108864);
      if (op == 0) return 0;
      if (op > max_op) return 3;
      if (op >= 1 && op <= 3) return 2;
      return 1;
   endfunction

   function automatic logic [31:0] ref_imm(logic [31:0] instr);
      logic [31:0] lo;
      lo = instr % 32'd65536;
      return (lo >= 32'd32768) ? lo + 32'hFFFF0000 : lo;
   endfunction

   function automatic int sat(int v, int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic chk_counts();
`ifdef DECODE_STATS_EN
      chk("cnt1_r", 32'(c1r), 32'(sat(cnt1[0], 16)));
      chk("cnt1_i", 32'(c1i), 32'(sat(cnt1[1], 16)));
      chk("cnt1_j", 32'(c1j), 32'(sat(cnt1[2], 16)));
      chk("cnt1_ill", 32'(c1x), 32'(sat(cnt1[3], 16)));
      chk("cnt2_r", 32'(c2r), 32'(sat(cnt2[0], 2)));
      chk("cnt2_i", 32'(c2i), 32'(sat(cnt2[1], 2)));
      chk("cnt2_j", 32'(c2j), 32'(sat(cnt2[2], 2)));
      chk("cnt2_ill", 32'(c2x), 32'(sat(cnt2[3], 2)));
`endif
   endtask

   // Check at negedge against the model, then advance across one edge.
   task automatic step();
      logic exp_rdy, acc, held;
      logic [31:0] e;
      @(negedge clk);
      held = (q_instr.size() != 0);
      exp_rdy = rst || flush || !held || out_ready;
      chk("in_ready", 32'(rdy1), 32'(exp_rdy));
      chk("in_ready2", 32'(rdy2), 32'(exp_rdy));
      chk("out_valid", 32'(val1), 32'(held));
      chk("out_valid2", 32'(val2), 32'(held));
      if (held) begin
         e = q_instr[0];
         chk("type", 32'(typ1), 32'(ref_type(e, 63)));
         chk("type2", 32'(typ2), 32'(ref_type(e, 40)));
         chk("opcode", 32'(op1), e / 32'd67108864);
         chk("rs", 32'(rs1), (e / 32'd2097152) % 32'd32);
         chk("rt", 32'(rt1), (e / 32'd65536) % 32'd32);
         chk("rd", 32'(rd1), (e / 32'd2048) % 32'd32);
         chk("shamt", 32'(sh1), (e / 32'd64) % 32'd32);
         chk("funct", 32'(fn1), e % 32'd64);
         chk("imm", imm1, ref_imm(e));
         chk("target", 32'(tg1), e % 32'd67108864);
         chk("pc", pc1, q_pc[0]);
      end
      chk_counts();
      acc = in_valid && exp_rdy && !flush && !rst;
      @(posedge clk);
      if (rst) begin
         q_instr.delete();
         q_pc.delete();
         cnt1 = '{0, 0, 0, 0};
         cnt2 = '{0, 0, 0, 0};
      end else begin
         if (flush || (held && out_ready)) begin
            q_instr.delete();
            q_pc.delete();
         end
         if (acc) begin
            q_instr.push_back(in_instr);
            q_pc.push_back(in_pc);
            cnt1[ref_type(in_instr, 63)]++;
            cnt2[ref_type(in_instr, 40)]++;
         end
      end
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  t1;
      logic [1:0]  t2;
      logic [31:0] imm;
      logic [25:0] tgt;
   } vec_t;

   vec_t vecs[9];
   int snap1[4];
   int snap2[4];

   initial begin
      vecs[0] = '{32'h00221820, 2'b00, 2'b00, 32'h00001820, 26'h0221820};
      vecs[1] = '{32'h08000010, 2'b10, 2'b10, 32'h00000010, 26'h0000010};
      vecs[2] = '{32'h8C220004, 2'b01, 2'b01, 32'h00000004, 26'h0220004};
      vecs[3] = '{32'h2001FFFF, 2'b01, 2'b01, 32'hFFFFFFFF, 26'h001FFFF};
      vecs[4] = '{32'h04008000, 2'b10, 2'b10, 32'hFFFF8000, 26'h0008000};
      vecs[5] = '{32'h0C007FFF, 2'b10, 2'b10, 32'h00007FFF, 26'h0007FFF};
      vecs[6] = '{32'h10000000, 2'b01, 2'b01, 32'h00000000, 26'h0000000};
      vecs[7] = '{32'hA0000001, 2'b01, 2'b01, 32'h00000001, 26'h0000001};
      vecs[8] = '{32'hFC000000, 2'b01, 2'b11, 32'h00000000, 26'h0000000};

      rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
      in_instr = 32'h00221820; in_pc = 32'h100;
      cnt1 = '{0, 0, 0, 0};
      cnt2 = '{0, 0, 0, 0};
      step();
      step();
      chk("rst_valid", 32'(val1), 32'd0);
      chk("rst_ready", 32'(rdy1), 32'd1);
      chk("rst_type", 32'(typ1), 32'd0);
      chk("rst_imm", imm1, 32'd0);
      chk("rst_pc", pc1, 32'd0);
      rst = 1'b0; in_valid = 1'b0;

      // Illegal opcode 0x30 on the MAX_OP=40 instance.
      in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hC0000000;
      step();
      in_valid = 1'b0;
      chk("ill_type2", 32'(typ2), 32'd3);
      chk("ill_type1", 32'(typ1), 32'd1);
`ifdef DECODE_STATS_EN
      chk("ill_cnt2", 32'(c2x), 32'd1);
`endif
      step();

      // Back-to-back streaming of the vector table.
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         in_instr = vecs[k].instr; in_pc = 32'h1000 + 32'(k * 4);
         step();
         chk("vec_valid", 32'(val1), 32'd1);
         chk("vec_type", 32'(typ1), 32'(vecs[k].t1));
         chk("vec_type2", 32'(typ2), 32'(vecs[k].t2));
         chk("vec_imm", imm1, vecs[k].imm);
         chk("vec_target", 32'(tg1), 32'(vecs[k].tgt));
         chk("vec_pc", pc1, 32'h1000 + 32'(k * 4));
      end
      in_valid = 1'b0;
      step();

      // Backpressure with the next instruction held on the input.
      in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h2001FFFF;
      step();
      in_instr = 32'h00000020; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_ready", 32'(rdy1), 32'd0);
         chk("bp_imm", imm1, 32'hFFFFFFFF);
         chk("bp_valid", 32'(val1), 32'd1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_next_imm", imm1, 32'h00000020);
      in_valid = 1'b0;
      step();

      // Accept and flush in the same cycle.
      snap1 = cnt1; snap2 = cnt2;
      in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00221820;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_valid", 32'(val1), 32'd0);
`ifdef DECODE_STATS_EN
      chk("fl_cnt_r", 32'(c1r), 32'(snap1[0]));
      chk("fl_cnt_i", 32'(c1i), 32'(snap1[1]));
      chk("fl_cnt2_r", 32'(c2r), 32'(sat(snap2[0], 2)));
`endif
      step();

      // Five R-type instructions saturate the 2-bit counter.
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_instr = 32'h00000020 + 32'(k);
         step();
      end
      in_valid = 1'b0;
      step();
`ifdef DECODE_STATS_EN
      chk("sat_cnt2_r", 32'(c2r), 32'd3);
`endif

      // Reset mid-stall drops the pending instruction.
      in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h8C220004;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_stall_valid", 32'(val1), 32'd0);
      chk("rst_stall_imm", imm1, 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 500; k++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 12) == 0;
         rst       = ($urandom % 64) == 0;
         in_pc     = $urandom;
         case ($urandom % 4)
            0: in_instr = $urandom % 32'h04000000;
            1: in_instr = ($urandom_range(1, 3) << 26) | ($urandom % 32'h04000000);
            default: in_instr = $urandom;
         endcase
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
